uart_tx_fifo: RTL and testbench
===============================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 Parameter DEPTH, default 16, FIFO depth in bytes; power of two, 2..256.
REQ-002 Parameter AW, default 4, address width; SHALL equal log2(DEPTH).
REQ-003 clk  input  1  single clock; all logic rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  producer write strobe, one byte per cycle.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 full  output  1  high when count==DEPTH.
REQ-008 empty  output  1  high when count==0.
REQ-009 count  output  AW+1  bytes currently stored.
REQ-010 tx_busy  input  1  busy flag from the downstream uart transmitter.
REQ-011 tx_start  output  1  one-cycle start pulse to the uart.
REQ-012 tx_data  output  8  byte presented to the uart.
REQ-013 ovf_count  output  8  dropped-write counter (see Configuration).

Function
REQ-014 Write SHALL be accepted when wr_en=1 and full=0; byte stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-015 wr_en=1 with full=1 SHALL be dropped; storage, pointers, count unchanged, even if a pop occurs in the same cycle.
REQ-016 Simultaneous accepted write and pop SHALL leave count unchanged.
REQ-017 Pointers SHALL wrap from DEPTH-1 to 0 without corrupting data.
REQ-018 Drain FSM states: IDLE, START, WAIT_BUSY, WAIT_DONE.
REQ-019 IDLE: if empty=0 and tx_busy=0, pop head byte into tx_data register and go to START; otherwise stay.
REQ-020 START: tx_start=1 for exactly this one cycle; go to WAIT_BUSY.
REQ-021 WAIT_BUSY: stay until tx_busy=1, then go to WAIT_DONE; if tx_busy is not seen within 16 cycles, go to IDLE (byte considered sent).
REQ-022 WAIT_DONE: stay while tx_busy=1; on tx_busy=0 go to IDLE.
REQ-023 tx_data SHALL be held stable from START until the next pop.
REQ-024 Latency: write to an empty FIFO with FSM in IDLE and tx_busy=0 at cycle N SHALL produce tx_start=1 in cycle N+2.
REQ-025 Back-to-back bytes SHALL be separated by at least one IDLE cycle after tx_busy falls.
REQ-026 full, empty, count SHALL be registered and reflect state after the current edge.

Reset
REQ-027 Reset SHALL act immediately, independent of clk.
REQ-028 During and after reset: pointers=0, count=0, empty=1, full=0, tx_start=0, tx_data=8'h00, ovf_count=0, FSM=IDLE.
REQ-029 Reset mid-transfer SHALL discard all stored bytes; no tx_start SHALL follow release until a new write.

Configuration
REQ-030 Macro UART_TX_FIFO_OVF_CNT_EN defined: ovf_count increments on every dropped write (REQ-015), saturating at 8'hFF.
REQ-031 Macro undefined: ovf_count port present, tied to 8'h00; no counter logic.

Verification
REQ-032 Reset, then write 8'hA5 once with tx_busy model idle -> tx_start pulse 2 cycles later, tx_data=8'hA5, empty=1.
REQ-033 Busy model (tx_busy high 2 cycles after tx_start, for 100 cycles); write 8'h01..8'h05 back-to-back -> five tx_start pulses in order 01..05, each after tx_busy falls, count peaks at 4 or 5.
REQ-034 Hold tx_busy=1, write 17 bytes with DEPTH=16 -> full=1 after 16th, 17th dropped, count=16; ovf_count=1 with macro, 0 without.
REQ-035 Fill to 16, release tx_busy and write during pops -> pointers wrap, output order matches write order across wrap boundary.
REQ-036 Assert reset during WAIT_DONE with 3 bytes queued -> all outputs at reset values at once; no tx_start after release.
REQ-037 Loopback through uart with rx=tx, send 8'h3C, 8'hC3 -> rx_data sequence 8'h3C then 8'hC3 on rx_done.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through a four-state drain FSM.
// Define UART_TX_FIFO_OVF_CNT_EN to count dropped writes on ovf_count (otherwise tied to zero).
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  input  logic          tx_busy,
  output logic          tx_start,
  output logic [7:0]    tx_data,
  output logic [7:0]    ovf_count
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] START     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [1:0]    state_q, state_d;
  logic [3:0]    tmo_q, tmo_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          wr_ok;
  logic          pop;

  // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
  assign wr_ok = wr_en & ~full_q;
  assign pop   = (state_q == IDLE) & ~empty_q & ~tx_busy;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    tx_data_d = tx_data_q;
    if (wr_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_ONE;
      tx_data_d = mem_q[rd_ptr_q];
    end
    case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
  end

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE:      if (pop) state_d = START;
      START: begin
        state_d = WAIT_BUSY;
        tmo_d   = '0;
      end
      // Give up after 16 cycles without busy and treat the byte as sent.
      WAIT_BUSY: begin
        if (tx_busy)              state_d = WAIT_DONE;
        else if (tmo_q == 4'hF)   state_d = IDLE;
        else                      tmo_d   = tmo_q + 4'd1;
      end
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      state_q   <= IDLE;
      tmo_q     <= '0;
      tx_data_q <= 8'h00;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      tx_data_q <= tx_data_d;
    end
  end

  assign full     = full_q;
  assign empty    = empty_q;
  assign count    = count_q;
  assign tx_start = (state_q == START);
  assign tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVF_CNT_EN
  logic [7:0] ovf_q, ovf_d;

  assign ovf_d = (wr_en && full_q && ovf_q != 8'hFF) ? ovf_q + 8'd1 : ovf_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) ovf_q <= 8'h00;
    else       ovf_q <= ovf_d;
  end

  assign ovf_count = ovf_q;
`else
  assign ovf_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: latency, busy handshake, full/drop, wrap, async reset, serial loopback.
module tb_uart_tx_fifo;

  localparam int BIT = 8;   // serial bit period in clocks

`ifdef UART_TX_FIFO_OVF_CNT_EN
  localparam logic [7:0] OVF_EXP = 8'h01;
`else
  localparam logic [7:0] OVF_EXP = 8'h00;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, empty, tx_start;
  logic [4:0] count;
  logic       tx_busy = 1'b0;
  logic [7:0] tx_data, ovf_count;
  logic       line = 1'b1;

  int         n_vec = 0;
  int         n_bad = 0;
  int         mode = 0;       // 0 none, 1 busy pulse model, 2 serial uart
  int         busy_len = 100;
  int         peak = 0;
  logic [7:0] start_q[$];
  logic [7:0] rx_q[$];

  uart_tx_fifo #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .count(count), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .ovf_count(ovf_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic put(input logic [7:0] b);
    wr_en = 1'b1;
    wr_data = b;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && start_q.size() < n; i++) @(negedge clk);
    check_eq(tag, start_q.size(), n);
  endtask

  // start monitor: every pulse must come with the transmitter idle
  initial begin
    forever begin
      @(negedge clk);
      if (count > peak) peak = count;
      if (tx_start) begin
        start_q.push_back(tx_data);
        check_eq("start_while_idle", tx_busy, 1'b0);
      end
    end
  end

  // downstream transmitter model, acting just after the sampling edge
  initial begin
    int dly;
    int len;
    logic [7:0] b;
    dly = 0;
    len = 0;
    forever begin
      @(negedge clk); #2;
      if (mode == 1) begin
        if (tx_start) dly = 2;
        else if (dly > 0) begin
          dly--;
          if (dly == 0) begin tx_busy = 1'b1; len = busy_len; end
        end else if (len > 0) begin
          len--;
          if (len == 0) tx_busy = 1'b0;
        end
      end else if (mode == 2) begin
        if (tx_start) begin
          b = tx_data;
          tx_busy = 1'b1;
          for (int k = 0; k < 10; k++) begin
            line = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            repeat (BIT) @(negedge clk);
            #2;
          end
          tx_busy = 1'b0;
        end
      end else begin
        dly = 0;
        len = 0;
      end
    end
  end

  // serial receiver on the looped-back line, sampling mid-bit
  initial begin
    logic [7:0] r;
    forever begin
      @(negedge line);
      #(BIT * 5);
      for (int k = 0; k < 8; k++) begin
        #(BIT * 10);
        r[k] = line;
      end
      #(BIT * 10);
      rx_q.push_back(r);
    end
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk);
    check_eq("rst_count", count, 0);
    check_eq("rst_empty", empty, 1);
    check_eq("rst_full", full, 0);
    check_eq("rst_tx_start", tx_start, 0);
    check_eq("rst_tx_data", tx_data, 8'h00);
    check_eq("rst_ovf", ovf_count, 8'h00);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // single byte, idle transmitter: start two cycles after the write
    put(8'hA5);
    @(negedge clk);
    check_eq("lat_n1_start", tx_start, 0);
    check_eq("lat_n1_count", count, 1);
    @(negedge clk);
    check_eq("lat_n2_start", tx_start, 1);
    check_eq("lat_n2_data", tx_data, 8'hA5);
    check_eq("lat_n2_empty", empty, 1);
    repeat (25) @(negedge clk);
    check_eq("hold_tx_data", tx_data, 8'hA5);
    start_q.delete();

    // five back-to-back bytes through the busy model
    busy_len = 100;
    mode = 1;
    peak = 0;
    for (int i = 1; i <= 5; i++) put(8'(i));
    wait_starts(5, 800, "burst_starts");
    for (int i = 0; i < 5 && i < start_q.size(); i++)
      check_eq($sformatf("burst_byte%0d", i), start_q[i], 8'(i + 1));
    check_eq("burst_peak", peak, 4);
    repeat (110) @(negedge clk);
    mode = 0;
    tx_busy = 1'b1;
    start_q.delete();

    // fill with busy held: 16th fills, 17th dropped
    for (int i = 0; i < 15; i++) put(8'h10 + 8'(i));
    @(negedge clk);
    check_eq("fill15_full", full, 0);
    check_eq("fill15_count", count, 15);
    put(8'h1F);
    @(negedge clk);
    check_eq("fill16_full", full, 1);
    check_eq("fill16_count", count, 16);
    put(8'h20);
    @(negedge clk);
    check_eq("drop_count", count, 16);
    check_eq("drop_full", full, 1);
    check_eq("drop_ovf", ovf_count, OVF_EXP);

    // drain while refilling: pointers wrap, order preserved
    busy_len = 3;
    tx_busy = 1'b0;
    mode = 1;
    for (int i = 0; i < 16; i++) begin
      repeat (11) @(negedge clk);
      put(8'h30 + 8'(i));
    end
    wait_starts(32, 600, "wrap_starts");
    for (int i = 0; i < 32 && i < start_q.size(); i++)
      check_eq($sformatf("wrap_byte%0d", i), start_q[i],
               (i < 16) ? 8'h10 + 8'(i) : 8'h30 + 8'(i - 16));
    check_eq("wrap_ovf", ovf_count, OVF_EXP);
    repeat (20) @(negedge clk);

    // async reset while waiting for the transmitter with three bytes queued
    busy_len = 100;
    for (int i = 0; i < 4; i++) put(8'h41 + 8'(i));
    for (int i = 0; i < 30 && !tx_busy; i++) @(negedge clk);
    check_eq("mid_busy_seen", tx_busy, 1);
    repeat (3) @(negedge clk);
    check_eq("mid_count", count, 3);
    #3 reset = 1'b1;
    #1;
    check_eq("arst_count", count, 0);
    check_eq("arst_empty", empty, 1);
    check_eq("arst_full", full, 0);
    check_eq("arst_tx_start", tx_start, 0);
    check_eq("arst_tx_data", tx_data, 8'h00);
    check_eq("arst_ovf", ovf_count, 8'h00);
    mode = 0;
    tx_busy = 1'b0;
    start_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check_eq("post_rst_starts", start_q.size(), 0);
    check_eq("post_rst_empty", empty, 1);

    // serial loopback
    mode = 2;
    put(8'h3C);
    put(8'hC3);
    for (int i = 0; i < 400 && rx_q.size() < 2; i++) @(negedge clk);
    check_eq("loop_rx_cnt", rx_q.size(), 2);
    if (rx_q.size() >= 2) begin
      check_eq("loop_rx0", rx_q[0], 8'h3C);
      check_eq("loop_rx1", rx_q[1], 8'hC3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
